rot_shift_seq: RTL and testbench

//  Multi-cycle shift/rotate execution unit for the 8-bit datapath. Moves one bit per clock.

---
 rtl/rot_shift_seq_pkg.sv | 21 ++
 rtl/rot_shift_seq_shift_step.sv | 50 +++++
 rtl/rot_shift_seq.sv | 106 ++++++++++
 tb/tb_rot_shift_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rot_shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// rot_shift_seq_pkg
//   Shared definitions for the sequential shift/rotate unit and its one-bit
//   step datapath: operation encodings and FSM state encodings.
// ---------------------------------------------------------------------------
package rot_shift_seq_pkg;

  // 3-bit operation encodings; 5..7 are reserved and behave as ROL.
  localparam logic [2:0] OP_ROL = 3'd0;
  localparam logic [2:0] OP_ROR = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_ASR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rot_shift_seq_shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
//   Combinational single-bit shift/rotate. Shared with the barrel-shift unit,
//   so it carries no state.
// Ports:
//   acc      in   WIDTH  value before the step
//   op       in   3      operation encoding (see rot_shift_seq_pkg)
//   next_acc out  WIDTH  value after one step
//   out_bit  out  1      bit moved out of the word by this step
// ---------------------------------------------------------------------------
module shift_step
  import rot_shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] next_acc,
  output logic             out_bit
);

  always_comb begin
    next_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
    out_bit  = acc[WIDTH-1];
    case (op)
      OP_ROR: begin
        next_acc = {acc[0], acc[WIDTH-1:1]};
        out_bit  = acc[0];
      end
      OP_SHL: begin
        next_acc = {acc[WIDTH-2:0], 1'b0};
        out_bit  = acc[WIDTH-1];
      end
      OP_SHR: begin
        next_acc = {1'b0, acc[WIDTH-1:1]};
        out_bit  = acc[0];
      end
      OP_ASR: begin
        next_acc = {acc[WIDTH-1], acc[WIDTH-1:1]};
        out_bit  = acc[0];
      end
      default: begin
        // ROL and the reserved encodings
        next_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
        out_bit  = acc[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/rot_shift_seq.sv
// ---------------------------------------------------------------------------
// rot_shift_seq
//   Multi-cycle shift/rotate unit moving one bit per clock, with a
//   start/busy/done handshake. Rotate results match rol8/ror8.
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, accepted only in IDLE or DONE
//   op     in   3      0 ROL, 1 ROR, 2 SHL, 3 SHR, 4 ASR, 5-7 as ROL
//   a      in   WIDTH  operand, captured on the accepted start edge
//   shamt  in   SHW    shift count, captured on the accepted start edge
//   busy   out  1      high while stepping
//   done   out  1      one-cycle completion pulse
//   y      out  WIDTH  result, held until the next completion
//   carry  out  1      last bit shifted out (0 for shamt==0)
//   zero   out  1      y == 0, registered with y
// ---------------------------------------------------------------------------
module rot_shift_seq
  import rot_shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [2:0]       opcode_reg;
  logic [WIDTH-1:0] y_reg;
  logic             carry_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] step_acc;
  logic             step_out;
  logic             accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .op       (opcode_reg),
    .next_acc (step_acc),
    .out_bit  (step_out)
  );

  // start is only honoured outside RUN; a request mid-operation is dropped.
  assign accept = start && (state_reg == ST_IDLE || state_reg == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cnt_reg == '0) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      opcode_reg <= OP_ROL;
      y_reg      <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
    end else if (accept) begin
      acc_reg    <= a;
      cnt_reg    <= shamt;
      opcode_reg <= op;
      carry_reg  <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (cnt_reg != '0) begin
        acc_reg   <= step_acc;
        carry_reg <= step_out;
        cnt_reg   <= cnt_reg - SHW'(1);
      end else begin
        // y/zero are published only here, so they stay stable through RUN.
        y_reg    <= acc_reg;
        zero_reg <= (acc_reg == '0);
      end
    end
  end

  assign busy  = (state_reg == ST_RUN);
  assign done  = (state_reg == ST_DONE);
  assign y     = y_reg;
  assign carry = carry_reg;
  assign zero  = zero_reg;

endmodule

// File: tb/tb_rot_shift_seq.sv
// ---------------------------------------------------------------------------
// tb_rot_shift_seq
//   Directed and exhaustive-rotate checks of rot_shift_seq.
// ---------------------------------------------------------------------------
module tb_rot_shift_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'h00;
  logic [2:0] shamt = 3'd0;
  logic       busy, done, carry, zero;
  logic [7:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  rot_shift_seq #(.WIDTH(8), .SHW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .carry (carry),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after the accept edge, and
  // wait (bounded) for done. cyc = edges from the start edge to done.
  task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [2:0] s,
                        output int cyc, output int bcnt);
    op = o; a = av; shamt = s; start = 1'b1;
    tick();
    start = 1'b0; a = 8'h5A; shamt = 3'd7; op = 3'd4;
    check("accept_done_low", {15'd0, done}, 16'd0);
    check("accept_busy", {15'd0, busy}, 16'd1);
    cyc  = 0;
    bcnt = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
      if (busy) bcnt++;
    end
    if (cyc >= 20) check("done_timeout", {15'd0, done}, 16'd1);
  endtask

  function automatic logic [7:0] rol8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] t;
    t = {v, v} << s;
    return t[15:8];
  endfunction

  function automatic logic [7:0] ror8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] t;
    t = {v, v} >> s;
    return t[7:0];
  endfunction

  initial begin
    int cyc, bcnt;
    logic [7:0] ey;
    logic       ec;

    #2 rst = 1'b1;
    tick(); tick();
    check("rst_y", {8'd0, y}, 16'h00);
    check("rst_carry", {15'd0, carry}, 16'd0);
    check("rst_zero", {15'd0, zero}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    tick();

    // 1. ROL 0x81 by 1
    run_op(3'd0, 8'h81, 3'd1, cyc, bcnt);
    $display("txn ROL a=81 sh=1 -> y=%02h c=%0b z=%0b cyc=%0d", y, carry, zero, cyc);
    check("t1_y", {8'd0, y}, 16'h03);
    check("t1_carry", {15'd0, carry}, 16'd1);
    check("t1_zero", {15'd0, zero}, 16'd0);
    check("t1_latency", 16'(cyc), 16'd2);
    tick();
    check("t1_done_pulse", {15'd0, done}, 16'd0);
    check("t1_y_hold", {8'd0, y}, 16'h03);
    check("t1_carry_hold", {15'd0, carry}, 16'd1);

    // 2. ROR 0x01 by 3
    run_op(3'd1, 8'h01, 3'd3, cyc, bcnt);
    $display("txn ROR a=01 sh=3 -> y=%02h c=%0b busy_cycles=%0d", y, carry, bcnt);
    check("t2_y", {8'd0, y}, 16'h20);
    check("t2_carry", {15'd0, carry}, 16'd0);
    check("t2_busy_cycles", 16'(bcnt), 16'd4);

    // 3. arithmetic / logical shifts
    run_op(3'd4, 8'h80, 3'd7, cyc, bcnt);
    $display("txn ASR a=80 sh=7 -> y=%02h c=%0b", y, carry);
    check("t3_asr_y", {8'd0, y}, 16'hFF);
    check("t3_asr_carry", {15'd0, carry}, 16'd0);
    run_op(3'd3, 8'h80, 3'd7, cyc, bcnt);
    $display("txn SHR a=80 sh=7 -> y=%02h c=%0b", y, carry);
    check("t3_shr_y", {8'd0, y}, 16'h01);
    check("t3_shr_carry", {15'd0, carry}, 16'd0);
    run_op(3'd2, 8'h80, 3'd1, cyc, bcnt);
    $display("txn SHL a=80 sh=1 -> y=%02h c=%0b z=%0b", y, carry, zero);
    check("t3_shl_y", {8'd0, y}, 16'h00);
    check("t3_shl_carry", {15'd0, carry}, 16'd1);
    check("t3_shl_zero", {15'd0, zero}, 16'd1);

    // 4. zero shift count clears carry, done after one edge
    run_op(3'd2, 8'hFF, 3'd0, cyc, bcnt);
    $display("txn SHL a=FF sh=0 -> y=%02h c=%0b z=%0b cyc=%0d", y, carry, zero, cyc);
    check("t4_y", {8'd0, y}, 16'hFF);
    check("t4_carry", {15'd0, carry}, 16'd0);
    check("t4_zero", {15'd0, zero}, 16'd0);
    check("t4_latency", 16'(cyc), 16'd1);

    // reserved opcode behaves as ROL
    run_op(3'd6, 8'h81, 3'd1, cyc, bcnt);
    $display("txn OP6 a=81 sh=1 -> y=%02h c=%0b", y, carry);
    check("rsv_y", {8'd0, y}, 16'h03);
    check("rsv_carry", {15'd0, carry}, 16'd1);
    tick();

    // 5a. start mid-RUN is ignored
    op = 3'd0; a = 8'h81; shamt = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'h00; op = 3'd2; shamt = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_mid", {15'd0, busy}, 16'd1);
    cyc = 3;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    $display("txn ROL a=81 sh=5 (mid-run start) -> y=%02h c=%0b cyc=%0d", y, carry, cyc);
    check("t5_y", {8'd0, y}, 16'h30);
    check("t5_carry", {15'd0, carry}, 16'd0);
    check("t5_latency", 16'(cyc), 16'd6);
    tick();

    // 5b. reset mid-RUN aborts at once
    op = 3'd2; a = 8'hFF; shamt = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("t5_pre_rst_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    $display("txn reset mid-run -> y=%02h c=%0b z=%0b busy=%0b done=%0b", y, carry, zero, busy, done);
    check("t5_rst_y", {8'd0, y}, 16'h00);
    check("t5_rst_carry", {15'd0, carry}, 16'd0);
    check("t5_rst_zero", {15'd0, zero}, 16'd0);
    check("t5_rst_busy", {15'd0, busy}, 16'd0);
    check("t5_rst_done", {15'd0, done}, 16'd0);
    tick();
    rst = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) bcnt++;
    end
    check("t5_no_done_after_rst", 16'(bcnt), 16'd0);

    // 6. exhaustive ROL/ROR, each start issued while the previous op is in DONE
    for (int o = 0; o < 2; o++) begin
      for (int av = 0; av < 256; av++) begin
        for (int s = 0; s < 8; s++) begin
          run_op(3'(o), 8'(av), 3'(s), cyc, bcnt);
          ey = (o == 0) ? rol8(8'(av), 3'(s)) : ror8(8'(av), 3'(s));
          ec = (s == 0) ? 1'b0 : ((o == 0) ? ey[0] : ey[7]);
          $display("txn %s a=%02h sh=%0d -> y=%02h c=%0b exp y=%02h c=%0b",
                   (o == 0) ? "ROL" : "ROR", av, s, y, carry, ey, ec);
          check("ex_y", {8'd0, y}, {8'd0, ey});
          check("ex_carry", {15'd0, carry}, {15'd0, ec});
          check("ex_zero", {15'd0, zero}, {15'd0, (ey == 8'h00)});
          check("ex_latency", 16'(cyc), 16'(s + 1));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
